// File: rtl/window_fetch_pkg.sv
// Shared constants and elaboration helpers for the K x K window fetcher.
package window_fetch_pkg;

    localparam int BORDER_CLAMP = 0;
    localparam int BORDER_ZERO  = 1;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int tap_count(input int k);
        return k * k;
    endfunction

endpackage

// File: rtl/window_fetch_param_rd_lat_pipe.sv
// Tracks each issued tap until its read data returns from memory.
module rd_lat_pipe
    import window_fetch_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int TW    = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tap,
    input  logic          in_zero,
    output logic          out_valid,
    output logic [TW-1:0] out_tap,
    output logic          out_zero
);

    logic          valid_q [DEPTH];
    logic          valid_d [DEPTH];
    logic [TW-1:0] tap_q   [DEPTH];
    logic [TW-1:0] tap_d   [DEPTH];
    logic          zero_q  [DEPTH];
    logic          zero_d  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_comb begin
                if (gi == 0) begin
                    valid_d[gi] = in_valid;
                    tap_d[gi]   = in_tap;
                    zero_d[gi]  = in_zero;
                end else begin
                    valid_d[gi] = valid_q[gi-1];
                    tap_d[gi]   = tap_q[gi-1];
                    zero_d[gi]  = zero_q[gi-1];
                end
            end

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    valid_q[gi] <= 1'b0;
                    tap_q[gi]   <= '0;
                    zero_q[gi]  <= 1'b0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    tap_q[gi]   <= tap_d[gi];
                    zero_q[gi]  <= zero_d[gi];
                end
            end
        end
    endgenerate

    assign out_valid = valid_q[DEPTH-1];
    assign out_tap   = tap_q[DEPTH-1];
    assign out_zero  = zero_q[DEPTH-1];

endmodule

// File: rtl/window_fetch_param.sv
// K x K neighbourhood fetcher: issues row-major reads around a centre pixel,
// resolves borders by clamping or zero padding, and presents the whole window.
module window_fetch_param
    import window_fetch_pkg::*;
#(
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64,
    parameter int K           = 3,
    parameter int DW          = 13,
    parameter int AW          = 12,
    parameter int RD_LAT      = 1,
    parameter int BORDER_MODE = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [AW-1:0]     center,
    output logic              rd_en,
    output logic [AW-1:0]     address,
    input  logic [DW-1:0]     data,
    output logic              busy,
    output logic              valid,
    output logic              err,
    output logic [K*K*DW-1:0] window
);

    localparam int KK  = tap_count(K);
    localparam int R   = (K - 1) / 2;
    localparam int LW  = clog2(IMG_W);
    localparam int TW  = (clog2(KK) < 1) ? 1 : clog2(KK);
    localparam int CW  = (clog2(K) < 1) ? 1 : clog2(K);
    localparam int DCW = (clog2(RD_LAT) < 1) ? 1 : clog2(RD_LAT);
    localparam int SW  = AW + 2;

    localparam logic signed [SW-1:0] H_MAX = SW'(IMG_H - 1);
    localparam logic signed [SW-1:0] W_MAX = SW'(IMG_W - 1);
    localparam logic signed [SW-1:0] R_S   = SW'(R);
    localparam logic [AW:0]          NPIX  = (AW+1)'(IMG_W * IMG_H);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    generate
        if ((IMG_W & (IMG_W - 1)) != 0) begin : g_bad_width
            $error("IMG_W must be a power of two");
        end
        if ((K % 2) == 0 || K < 1) begin : g_bad_k
            $error("K must be odd and at least 1");
        end
        if (RD_LAT < 1) begin : g_bad_lat
            $error("RD_LAT must be at least 1");
        end
        if (IMG_W * IMG_H > (1 << AW)) begin : g_bad_aw
            $error("image does not fit the address width");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       row_q, row_d, col_q, col_d, addr_q, addr_d;
    logic [CW-1:0]       ky_q, ky_d, kx_q, kx_d;
    logic [TW-1:0]       tap_q, tap_d;
    logic [DCW-1:0]      drain_q, drain_d;
    logic                busy_q, busy_d, valid_q, valid_d, err_q, err_d, bad_q, bad_d;
    logic [DW-1:0]       working_q [KK];
    logic [DW-1:0]       working_d [KK];
    logic [KK*DW-1:0]    window_q, window_d;

    logic signed [SW-1:0] nr, nc, nr_c, nc_c;
    logic                 in_range, tap_zero, issue_rd;
    logic [AW-1:0]        addr_calc;
    logic                 pipe_valid, pipe_zero;
    logic [TW-1:0]        pipe_tap;

    always_comb begin
        nr = $signed(SW'(row_q)) + $signed(SW'(ky_q)) - R_S;
        nc = $signed(SW'(col_q)) + $signed(SW'(kx_q)) - R_S;
        nr_c = nr;
        if (nr[SW-1]) nr_c = '0;
        else if (nr > H_MAX) nr_c = H_MAX;
        nc_c = nc;
        if (nc[SW-1]) nc_c = '0;
        else if (nc > W_MAX) nc_c = W_MAX;
        in_range  = !nr[SW-1] && (nr <= H_MAX) && !nc[SW-1] && (nc <= W_MAX);
        addr_calc = (nr_c[AW-1:0] << LW) | nc_c[AW-1:0];
        tap_zero  = (BORDER_MODE == BORDER_ZERO) && !in_range;
        issue_rd  = (state_q == S_ISSUE) && !tap_zero;
    end

    // Skipped zero-pad taps leave the address bus at its last value.
    assign rd_en   = issue_rd;
    assign address = issue_rd ? addr_calc : addr_q;

    rd_lat_pipe #(
        .DEPTH (RD_LAT),
        .TW    (TW)
    ) u_pipe (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (state_q == S_ISSUE),
        .in_tap    (tap_q),
        .in_zero   (tap_zero),
        .out_valid (pipe_valid),
        .out_tap   (pipe_tap),
        .out_zero  (pipe_zero)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        addr_d   = address;
        ky_d     = ky_q;
        kx_d     = kx_q;
        tap_d    = tap_q;
        drain_d  = drain_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        bad_d    = bad_q;
        window_d = window_q;
        for (int t = 0; t < KK; t++) working_d[t] = working_q[t];
        if (pipe_valid) working_d[pipe_tap] = pipe_zero ? '0 : data;

        case (state_q)
            S_IDLE: begin
                // The valid cycle itself never accepts a new request.
                if (start && !valid_q) begin
                    row_d  = center >> LW;
                    col_d  = center & AW'(IMG_W - 1);
                    ky_d   = '0;
                    kx_d   = '0;
                    tap_d  = '0;
                    busy_d = 1'b1;
                    if ({1'b0, center} >= NPIX) begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                        for (int t = 0; t < KK; t++) working_d[t] = '0;
                    end else begin
                        bad_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tap_d = tap_q + 1'b1;
                if (kx_q == CW'(K - 1)) begin
                    kx_d = '0;
                    ky_d = ky_q + 1'b1;
                end else begin
                    kx_d = kx_q + 1'b1;
                end
                if (kx_q == CW'(K - 1) && ky_q == CW'(K - 1)) begin
                    if (RD_LAT == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DCW'(RD_LAT - 2);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else drain_d = drain_q - 1'b1;
            end
            default: begin
                // The final tap is captured on this same edge, hence working_d.
                for (int t = 0; t < KK; t++) window_d[t*DW +: DW] = working_d[t];
                valid_d = 1'b1;
                err_d   = bad_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            tap_q    <= '0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
            window_q <= '0;
            for (int t = 0; t < KK; t++) working_q[t] <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            tap_q    <= tap_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
            window_q <= window_d;
            for (int t = 0; t < KK; t++) working_q[t] <= working_d[t];
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign window = window_q;

endmodule

// File: doc/window_fetch_param.md
Name: window_fetch_param

Overview:
- Parametrised K×K neighbourhood fetcher for the image pipeline.
- On a start handshake it takes a centre pixel index and issues K*K row-major reads to the image ROM/RAM, with configurable read latency.
- It resolves image borders by clamping (edge replicate) or zero-padding, then presents the complete window as one flat vector with a one-cycle valid pulse.
- It feeds the convolution/kernel stage in place of the fixed 3×3, 64×64 fetcher.

Parameters:
- IMG_W, 64, image width in pixels; must be a power of two (elaboration-time check).
- IMG_H, 64, image height in pixels.
- K, 3, kernel side; must be odd and ≥1. R=(K-1)/2.
- DW, 13, pixel data width.
- AW, 12, address width; IMG_W*IMG_H ≤ 2**AW.
- RD_LAT, 1, memory read latency in cycles; must be ≥1.
- BORDER_MODE, 0, border handling: 0 = clamp/replicate, 1 = zero-pad.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- center  in  AW  centre pixel index, sampled on an accepted start.
- rd_en  out  1  memory read strobe.
- address  out  AW  memory read address.
- data  in  DW  memory read data; valid RD_LAT cycles after rd_en.
- busy  out  1  high from the cycle after accept until valid.
- valid  out  1  one-cycle pulse: window updated.
- err  out  1  qualifies valid: centre was out of range.
- window  out  K*K*DW  tap t occupies bits [t*DW +: DW]; t = ky*K + kx.

Behaviour:
- Reset:
  - rd_en, address, busy, valid, err and window are all 0; FSM goes to IDLE.
  - Reset mid-fetch aborts the fetch and discards in-flight reads (pipeline valid bits cleared).
- FSM states and transitions:
  - IDLE: start=1 latches center, row = center>>log2(IMG_W), col = center & (IMG_W-1).
    - If center ≥ IMG_W*IMG_H, go to DONE with err=1 and zero all working taps.
    - Otherwise go to ISSUE.
  - ISSUE: one tap per cycle, t = 0..K*K-1, using tap counters ky/kx (no divider). dy = ky-R, dx = kx-R, nr = row+dy, nc = col+dx, computed signed, one bit wider than needed.
    - Clamp mode: nr is clamped to [0, IMG_H-1] and nc to [0, IMG_W-1]. address = nr*IMG_W + nc (shift/or), rd_en=1.
    - Zero mode, tap in range: same as clamp mode.
    - Zero mode, tap out of range: rd_en=0, address holds its previous value, tap is marked zero.
    - Tap index and zero flag enter an RD_LAT-deep shift pipeline.
    - After tap K*K-1 go to DRAIN.
  - DRAIN: wait until the pipeline is empty.
  - DONE: copy the working taps to window, pulse valid (with err), go to IDLE.
- Capture: when a pipeline entry emerges, working[tap] <= zero_flag ? 0 : data.
- window is double-buffered. It changes only in the valid cycle and stays stable through the following fetch.
- Latency: start accepted at cycle 0; taps issued cycles 1..K*K; valid at cycle K*K+RD_LAT+1.
- The error path asserts valid at cycle 2.
- valid may coincide with a new start only via IDLE. A start in the valid cycle is ignored; the earliest accept is the cycle after valid.
- start while busy is ignored and center is not resampled.
- K=1: single read; window = data at center.
- Corner cases (row=0, col=IMG_W-1, etc.) follow the same clamp/zero rules. There is no wrap across rows.

Decomposition:
- Shared package window_fetch_pkg holds:
  - border mode constants BORDER_CLAMP=0 and BORDER_ZERO=1;
  - function clog2;
  - tap-count function K*K.
- One sub-module, rd_lat_pipe: a parametrised shift register of {valid, tap_idx, zero_flag}, depth RD_LAT, cleared on n_rst.

Test Plan:
All cases use a ROM model with mem[a] = a+100 and RD_LAT=1 unless stated; K=3, 64×64.
- Clamp, center=0 -> window taps t0..t8 = 100,100,101,100,100,101,164,164,165; valid at cycle 11.
- Zero-pad, center=0 -> taps = 0,0,0,0,100,101,0,164,165; rd_en high for exactly 4 cycles.
- Zero-pad, center=4095 -> taps = 4130,4131,0,4194,4195,0,0,0,0.
- K=5, RD_LAT=2, clamp, center=130 -> t0=100, t12=230, t24=360; valid at cycle 28.
- center=5000 (≥4096) -> valid at cycle 2 with err=1, window all zero, no rd_en.
- Reset asserted during ISSUE, then start with center=65 -> no stale valid; window = 100,101,102,164,165,166,228,229,230. Also: a start pulse while busy is ignored.
